time_display: RTL

Six-digit multiplexed 7-segment driver for the clock's `hours`/`mins`/`secs` outputs, placed between the timekeeping block and the board's common-anode display. It snapshots the time and mode once per scan frame and converts each field to two decimal digits. It scans one digit at a time and blinks the field currently selected for setting.

---
 rtl/time_display_pkg.sv | 32 +++
 rtl/seg7_encode.sv | 32 +++
 rtl/time_display.sv | 126 ++++++++++++
 3 files changed

// File: rtl/time_display_pkg.sv
// Shared constants for the six-digit time display driver.
// Mode encodings, active-low segment codes and decimal split helpers.
package time_display_pkg;

   localparam logic [1:0] MODE_RUN      = 2'b00;
   localparam logic [1:0] MODE_SET_SEC  = 2'b01;
   localparam logic [1:0] MODE_SET_MIN  = 2'b10;
   localparam logic [1:0] MODE_SET_HOUR = 2'b11;

   // Segment order {g,f,e,d,c,b,a}, 0 = lit.
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic logic [3:0] tens_of(input logic [5:0] v);
      return 4'(v / 6'd10);
   endfunction

   function automatic logic [3:0] ones_of(input logic [5:0] v);
      return 4'(v % 6'd10);
   endfunction

endpackage

// File: rtl/seg7_encode.sv
// Decimal digit to active-low 7-segment pattern.
// A set dash flag overrides the digit.
module seg7_encode
   import time_display_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       dash,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (dash) begin
         seg = SEG_DASH;
      end else begin
         case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/time_display.sv
// Multiplexed six-digit HH:MM:SS driver for a common-anode display.
// Time and mode are captured once per frame; the field being set blinks.
module time_display
   import time_display_pkg::*;
#(
   parameter int DWELL      = 8_333,
   parameter int BLINK_HALF = 12_500_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] hours,
   input  logic [5:0] mins,
   input  logic [5:0] secs,
   input  logic [1:0] mode,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   logic [DW-1:0] dwell;
   logic [BW-1:0] bcnt;
   logic [2:0]    idx;
   logic          phase;
   logic [5:0]    snap_h;
   logic [5:0]    snap_m;
   logic [5:0]    snap_s;
   logic [1:0]    snap_mode;

   logic          dwell_wrap;
   logic          blink_wrap;
   logic [5:0]    field;
   logic          dash;
   logic [3:0]    digit;
   logic          sel;
   logic          blank;
   logic [6:0]    enc;
   logic [5:0]    an_nxt;
   logic [6:0]    seg_nxt;
   logic          dp_nxt;

   assign dwell_wrap = (dwell == DW'(DWELL - 1));
   assign blink_wrap = (bcnt == BW'(BLINK_HALF - 1));

   // Field select and decimal split; idx[0] picks the tens digit.
   always_comb begin
      field = snap_h;
      dash  = 1'b0;
      case (idx)
         3'd0, 3'd1: begin
            field = snap_s;
            dash  = (snap_s > 6'd59);
         end
         3'd2, 3'd3: begin
            field = snap_m;
            dash  = (snap_m > 6'd59);
         end
         default: begin
            field = snap_h;
            dash  = (snap_h > 6'd23);
         end
      endcase
      digit = idx[0] ? tens_of(field) : ones_of(field);
   end

   seg7_encode u_enc (
      .digit (digit),
      .dash  (dash),
      .seg   (enc)
   );

   always_comb begin
      sel = 1'b0;
      case (snap_mode)
         MODE_SET_SEC:  sel = (idx == 3'd0) || (idx == 3'd1);
         MODE_SET_MIN:  sel = (idx == 3'd2) || (idx == 3'd3);
         MODE_SET_HOUR: sel = (idx == 3'd4) || (idx == 3'd5);
         default:       sel = 1'b0;
      endcase
      blank   = !phase && sel;
      an_nxt  = blank ? 6'b111111 : ~(6'b000001 << idx);
      seg_nxt = blank ? SEG_BLANK : enc;
      dp_nxt  = blank || !((idx == 3'd2) || (idx == 3'd4));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dwell     <= '0;
         idx       <= '0;
         bcnt      <= '0;
         phase     <= 1'b1;
         snap_h    <= '0;
         snap_m    <= '0;
         snap_s    <= '0;
         snap_mode <= MODE_RUN;
         an        <= 6'b111111;
         seg       <= SEG_BLANK;
         dp        <= 1'b1;
      end else begin
         if (dwell_wrap) begin
            dwell <= '0;
            idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
         end else begin
            dwell <= dwell + DW'(1);
         end
         if (dwell_wrap && idx == 3'd5) begin
            snap_h    <= hours;
            snap_m    <= mins;
            snap_s    <= secs;
            snap_mode <= mode;
         end
         if (blink_wrap) begin
            bcnt  <= '0;
            phase <= ~phase;
         end else begin
            bcnt <= bcnt + BW'(1);
         end
         an  <= an_nxt;
         seg <= seg_nxt;
         dp  <= dp_nxt;
      end
   end

endmodule
